// File: rtl/mmc1_serial_writer.sv
// MMC1 serial register writer: turns a 5-bit register load (or a shift-reset)
// into emulated 6502 write cycles on the cartridge bus, one bit per write.
module mmc1_serial_writer #(
    parameter int M2_DIV     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_reg,
    input  logic [4:0] cmd_data,
    input  logic       cmd_reset,
    output logic       busy,
    output logic       done,
    output logic       CPU_M2,
    output logic       nCPU_ROMSEL,
    output logic       nCPU_RW,
    output logic       CPU_A13,
    output logic       CPU_A14,
    output logic       CPU_D0,
    output logic       CPU_D7,
    output logic       CPU_D_OE
);

    localparam int PH_W  = $clog2(2 * M2_DIV);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * M2_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(M2_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       NUM_BITS = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, GAP} state_t;

    state_t           state, state_next;
    logic [PH_W-1:0]  ph, ph_next;
    logic             bus_start, m2_next, wr_next, accept, more;
    logic [1:0]       reg_lat;
    logic [4:0]       data_sr;
    logic             reset_lat;
    logic [2:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       src_reg;
    logic             src_d0, src_reset;

    always_comb begin
        bus_start = (ph == PH_LAST);
        ph_next   = bus_start ? '0 : ph + 1'b1;
        m2_next   = (ph_next >= PH_HALF);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        more       = !reset_lat && (bit_cnt != NUM_BITS);
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = bus_start ? WRITE : WAIT;
                end
            end
            WAIT:  if (bus_start) state_next = WRITE;
            WRITE: if (bus_start) state_next = GAP;
            GAP: begin
                if (bus_start && gap_cnt == GAP_LAST)
                    state_next = more ? WRITE : IDLE;
            end
            default: state_next = IDLE;
        endcase
        wr_next = (state_next == WRITE);
        // Accept on the last phase goes straight to WRITE, so the bus must
        // be loaded from the command inputs before they are latched.
        if (accept) begin
            src_reg   = cmd_reg;
            src_d0    = cmd_data[0];
            src_reset = cmd_reset;
        end else begin
            src_reg   = reg_lat;
            src_d0    = data_sr[0];
            src_reset = reset_lat;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ph        <= '0;
            reg_lat   <= '0;
            data_sr   <= '0;
            reset_lat <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            ph <= ph_next;
            if (accept) begin
                reg_lat   <= cmd_reg;
                data_sr   <= cmd_data;
                reset_lat <= cmd_reset;
                bit_cnt   <= '0;
            end
            if (state == WRITE && bus_start) begin
                data_sr <= {1'b0, data_sr[4:1]};
                bit_cnt <= bit_cnt + 1'b1;
                gap_cnt <= '0;
            end else if (state == GAP && bus_start) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            CPU_M2      <= 1'b0;
            nCPU_ROMSEL <= 1'b1;
            nCPU_RW     <= 1'b1;
            CPU_D_OE    <= 1'b0;
            CPU_A13     <= 1'b0;
            CPU_A14     <= 1'b0;
            CPU_D0      <= 1'b0;
            CPU_D7      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            CPU_M2      <= m2_next;
            nCPU_ROMSEL <= !(wr_next && m2_next);
            nCPU_RW     <= !wr_next;
            CPU_D_OE    <= wr_next;
            if (wr_next && state != WRITE) begin
                {CPU_A14, CPU_A13} <= src_reset ? 2'b00 : src_reg;
                CPU_D0             <= src_d0 && !src_reset;
                CPU_D7             <= src_reset;
            end
            busy      <= (state_next != IDLE);
            cmd_ready <= (state_next == IDLE);
            done      <= (state_next == IDLE) && (state != IDLE);
        end
    end

endmodule
